// File: rtl/inst_itf_pkg.sv
// Shared definitions for the instruction-fetch response block:
// FSM state encoding and the word-alignment mask.
package inst_itf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    LAT,
    RESP
  } state_e;

  // Low address bits that must be zero for a word-aligned fetch.
  localparam logic [31:0] WORD_ALIGN_MASK = 32'h3;

endpackage

// File: rtl/inst_itf_rsp.sv
// Instruction-fetch responder in front of an external synchronous SRAM.
// Accepts one held request at a time, inserts WAIT_CYCLES wait states,
// reads one word and returns a single-cycle registered ack.
// Optional feature macro: INST_RSP_PARITY_EN (adds mem_rpar_i even-parity check).
import inst_itf_pkg::*;

module inst_itf_rsp #(
  parameter logic [31:0] ADDR_BASE   = 32'h0,
  parameter logic [31:0] ADDR_END    = 32'h0fff,
  parameter int          WAIT_CYCLES = 2,
  parameter int          MEM_AW      = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inst_req_i,
  input  logic [31:0]       inst_addr_i,
  output logic              inst_ack_o,
  output logic [31:0]       inst_data_o,
  output logic              inst_error_o,
  output logic              mem_en_o,
  output logic [MEM_AW-1:0] mem_addr_o,
`ifdef INST_RSP_PARITY_EN
  input  logic              mem_rpar_i,
`endif
  input  logic [31:0]       mem_rdata_i
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        ack_d, err_d;
  logic [31:0] data_d;
  logic [31:0] req_off;
  logic        req_ok;

  // Range test as an unsigned offset compare so a zero base never yields
  // a constant comparison; alignment via the shared mask.
  always_comb begin
    req_off = inst_addr_i - ADDR_BASE;
    req_ok  = (req_off <= (ADDR_END - ADDR_BASE)) &&
              ((inst_addr_i & WORD_ALIGN_MASK) == 32'h0);
  end

  // State, counter, captured address and registered response outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 32'h0;
      inst_ack_o   <= 1'b0;
      inst_data_o  <= 32'h0;
      inst_error_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      inst_ack_o   <= ack_d;
      inst_data_o  <= data_d;
      inst_error_o <= err_d;
    end
  end

  // Next-state and next-output logic; response regs default to zero so
  // data/error are only non-zero in the ack cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ack_d   = 1'b0;
    data_d  = 32'h0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (inst_req_i) begin
          addr_d = inst_addr_i;
          if (req_ok) begin
            if (WAIT_CYCLES > 0) begin
              state_d = WAIT;
              cnt_d   = 4'(WAIT_CYCLES - 1);
            end else begin
              state_d = READ;
            end
          end else begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = READ;
        else               cnt_d   = cnt_q - 4'd1;
      end
      READ: state_d = LAT;
      LAT: begin
        ack_d   = 1'b1;
        data_d  = mem_rdata_i;
        state_d = RESP;
`ifdef INST_RSP_PARITY_EN
        if (mem_rpar_i != ^mem_rdata_i) begin
          data_d = 32'h0;
          err_d  = 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM strobe is a decode of the registered state; address held at zero
  // outside READ to keep the bus quiet.
  always_comb begin
    mem_en_o   = (state_q == READ);
    mem_addr_o = '0;
    if (state_q == READ) mem_addr_o = MEM_AW'((addr_q - ADDR_BASE) >> 2);
  end

endmodule

// File: doc/inst_itf_rsp.md
INST_ITF_RSP -- requirements
Module: inst_itf_rsp

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0, meaning the lowest byte address served.
REQ-002 SHALL have parameter ADDR_END, default 32'h0fff, meaning the highest byte address served (inclusive).
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, range 0..15, meaning wait states inserted before the SRAM read.
REQ-004 SHALL have parameter MEM_AW, default 10, meaning the SRAM word-address width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk_i, input, 1, rising-edge clock.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port inst_req_i, input, 1, fetch request, held high until ack.
REQ-008 SHALL have port inst_addr_i, input, 32, fetch byte address.
REQ-009 SHALL have port inst_ack_o, output, 1, single-cycle response strobe.
REQ-010 SHALL have port inst_data_o, output, 32, instruction word, valid with ack.
REQ-011 SHALL have port inst_error_o, output, 1, access error, valid with ack.
REQ-012 SHALL have port mem_en_o, output, 1, SRAM read enable.
REQ-013 SHALL have port mem_addr_o, output, MEM_AW, SRAM word address.
REQ-014 SHALL have port mem_rdata_i, input, 32, SRAM read data, valid one cycle after mem_en_o.
REQ-015 SHALL have port mem_rpar_i, input, 1, SRAM even parity of read data; present only under the configuration macro.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, READ, LAT, RESP.
REQ-017 IDLE with inst_req_i=1 SHALL capture inst_addr_i into addr_q.
- Address in range and addr[1:0]==0: go to WAIT if WAIT_CYCLES>0, else READ.
- Otherwise: flag error and go to RESP.
REQ-018 WAIT SHALL count WAIT_CYCLES cycles with a 4-bit down-counter, then go to READ.
REQ-019 READ SHALL drive mem_en_o=1 and mem_addr_o=(addr_q-ADDR_BASE)>>2 truncated to MEM_AW bits, then go to LAT.
REQ-020 LAT SHALL register mem_rdata_i into the inst_data_o register and go to RESP.
REQ-021 RESP SHALL assert inst_ack_o for exactly one cycle, then go to IDLE.
REQ-022 Valid-access latency SHALL be 3+WAIT_CYCLES cycles from the first inst_req_i high cycle in IDLE to inst_ack_o high.
REQ-023 Error-access latency SHALL be 1 cycle, with no SRAM access, inst_data_o=0 and inst_error_o=1.
REQ-024 inst_ack_o, inst_data_o and inst_error_o SHALL be registered outputs.
REQ-025 inst_data_o and inst_error_o SHALL be 0 whenever inst_ack_o=0.
REQ-026 mem_en_o SHALL be 0 outside READ; mem_addr_o SHALL be don't-care outside READ.
REQ-027 The IDLE entered after RESP SHALL accept a new request in the cycle after the ack, because the requester drops req one cycle after seeing ack.
REQ-028 inst_req_i and inst_addr_i changes after capture SHALL be ignored; a transaction once started SHALL always complete with an ack.

Reset
REQ-029 rst_i=1 SHALL force, asynchronously, state IDLE, counter 0, addr_q 0, and all outputs 0, including mid-transaction.
REQ-030 No ack SHALL be produced for a transaction interrupted by reset.

Configuration
REQ-031 Macro INST_RSP_PARITY_EN, when defined:
- mem_rpar_i SHALL exist.
- LAT SHALL compare mem_rpar_i with ^mem_rdata_i.
- On mismatch, RESP SHALL present inst_error_o=1 and inst_data_o=0.
REQ-032 Macro INST_RSP_PARITY_EN undefined: mem_rpar_i SHALL be absent and SRAM data SHALL never raise an error.

Structure
REQ-033 Shared package inst_itf_pkg SHALL hold the FSM state enum and the word-alignment constant.
REQ-034 No sub-module SHALL be used; the SRAM is external.

Verification
REQ-035 Bench SHALL cover: WAIT_CYCLES=2, req addr 0x10, mem word 4 = 0xDEADBEEF -> mem_en at cycle 3 with addr 4, ack at cycle 5, data 0xDEADBEEF, error 0.
REQ-036 Bench SHALL cover: req addr 0x2000 (out of range) -> ack at cycle 1, error 1, data 0, mem_en never asserted.
REQ-037 Bench SHALL cover: req addr 0x6 (misaligned) -> ack at cycle 1, error 1.
REQ-038 Bench SHALL cover: back-to-back requests to 0x0 then 0x4 with WAIT_CYCLES=0 -> two single-cycle acks 4 cycles apart with correct data.
REQ-039 Bench SHALL cover: rst_i pulsed while in WAIT -> no ack, all outputs 0; the next request completes normally.
REQ-040 Bench SHALL cover, with INST_RSP_PARITY_EN defined: wrong mem_rpar_i -> ack with error 1, data 0.
